// File: rtl/exc_mem_window_chk_if.sv
// Purpose: M-stage / CP0 bundle for the memory-stage exception checker.
// Signals: pipeline control (stall, flush), M-stage access (valid_m, exc_in,
//          addr, mem_rd, mem_wr, size, pc_m, bd_m), CP0 ack (exc_ack), and the
//          checker results (we_safe, exc_w, badvaddr, epc, exc_req, stall_req,
//          exc_cnt).
// master: pipeline/CP0 side, drives requests and reads results.
// slave : the checker.
interface exc_mem_window_chk_if #(
   parameter int unsigned CNT_W = 16
);
   logic             stall;
   logic             flush;
   logic             valid_m;
   logic [4:0]       exc_in;
   logic [31:0]      addr;
   logic             mem_rd;
   logic             mem_wr;
   logic [1:0]       size;
   logic [31:0]      pc_m;
   logic             bd_m;
   logic             exc_ack;
   logic             we_safe;
   logic [4:0]       exc_w;
   logic [31:0]      badvaddr;
   logic [31:0]      epc;
   logic             exc_req;
   logic             stall_req;
   logic [CNT_W-1:0] exc_cnt;

   modport master (
      output stall, flush, valid_m, exc_in, addr, mem_rd, mem_wr, size,
             pc_m, bd_m, exc_ack,
      input  we_safe, exc_w, badvaddr, epc, exc_req, stall_req, exc_cnt
   );

   modport slave (
      input  stall, flush, valid_m, exc_in, addr, mem_rd, mem_wr, size,
             pc_m, bd_m, exc_ack,
      output we_safe, exc_w, badvaddr, epc, exc_req, stall_req, exc_cnt
   );
endinterface

// File: rtl/exc_mem_window_chk.sv
// Purpose: memory-stage exception checker. Classifies each M-stage load/store
// against RAM [0, MEM_HI] and DEV_NUM device windows, flags misalignment,
// non-word device accesses and stores to the read-only device register,
// gates the store strobe, and captures ExcCode/BadVAddr/EPC into W, holding
// them toward CP0 until acknowledged.
// Ports: clk, rst_n (async active-low), bus (slave modport of
//        exc_mem_window_chk_if carrying all pipeline and CP0 signals).
module exc_mem_window_chk #(
   parameter int unsigned         DEV_NUM    = 2,
   parameter logic [32*DEV_NUM-1:0] DEV_BASE = {32'h00007f10, 32'h00007f00},
   parameter int unsigned         DEV_SIZE   = 12,
   parameter int unsigned         DEV_RO_OFF = 8,
   parameter logic [31:0]         MEM_HI     = 32'h00002fff,
   parameter int unsigned         CNT_W      = 16
) (
   input logic                clk,
   input logic                rst_n,
   exc_mem_window_chk_if.slave bus
);

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   typedef enum logic {IDLE, PEND} state_t;

   state_t           state_q, state_d;
   logic [4:0]       exc_w_q, exc_w_d;
   logic [31:0]      bad_q, bad_d;
   logic [31:0]      epc_q, epc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [DEV_NUM-1:0] hit_dev;
   logic               ro_hit;
   logic               hit_mem;
   logic               legal;
   logic               misalign;
   logic               narrow;
   logic [4:0]         code_now;

   // Device window decode; offset is taken 33 bits wide so base+size never wraps.
   always_comb begin
      logic [31:0] base;
      logic [32:0] off;
      hit_dev = '0;
      ro_hit  = 1'b0;
      base    = '0;
      off     = '0;
      for (int i = 0; i < int'(DEV_NUM); i++) begin
         base = DEV_BASE[32*i +: 32];
         off  = {1'b0, bus.addr} - {1'b0, base};
         if ((bus.addr >= base) && (off < 33'(DEV_SIZE))) begin
            hit_dev[i] = 1'b1;
            if (off == 33'(DEV_RO_OFF)) begin
               ro_hit = 1'b1;
            end
         end
      end
   end

   // Access legality and exception code for the current M-stage instruction.
   always_comb begin
      hit_mem = (bus.addr <= MEM_HI);
      legal   = hit_mem | (|hit_dev);
      unique case (bus.size)
         2'd0:    misalign = 1'b0;
         2'd1:    misalign = bus.addr[0];
         2'd2:    misalign = (bus.addr[1:0] != 2'b00);
         default: misalign = 1'b1;
      endcase
      narrow = (|hit_dev) & (bus.size != 2'd2);

      code_now = EXC_NONE;
      if (bus.valid_m) begin
         if (bus.exc_in != EXC_NONE) begin
            code_now = bus.exc_in;
         end else if (bus.mem_wr) begin
            if (!legal || misalign || narrow || ro_hit) code_now = EXC_ADES;
         end else if (bus.mem_rd) begin
            if (!legal || misalign || narrow) code_now = EXC_ADEL;
         end
      end
   end

   // Next-state and W-stage capture.
   always_comb begin
      state_d = state_q;
      exc_w_d = exc_w_q;
      bad_d   = bad_q;
      epc_d   = epc_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (!bus.stall) begin
               if (bus.flush) begin
                  exc_w_d = EXC_NONE;
               end else begin
                  exc_w_d = code_now;
                  if (code_now != EXC_NONE) begin
                     epc_d = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;
                     // Own fault reports the data address; fetch AdEL reports the PC.
                     if (bus.exc_in == EXC_NONE) begin
                        bad_d = bus.addr;
                     end else if (bus.exc_in == EXC_ADEL) begin
                        bad_d = bus.pc_m;
                     end
                     state_d = PEND;
                     if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
         end
         PEND: begin
            if (bus.exc_ack) begin
               state_d = IDLE;
               exc_w_d = EXC_NONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and W-stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         exc_w_q <= EXC_NONE;
         bad_q   <= '0;
         epc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         exc_w_q <= exc_w_d;
         bad_q   <= bad_d;
         epc_q   <= epc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Store strobe is killed combinationally by any fault, pending exception or flush.
   assign bus.we_safe   = bus.mem_wr & bus.valid_m & (code_now == EXC_NONE)
                          & (state_q == IDLE) & ~bus.flush;
   assign bus.exc_w     = exc_w_q;
   assign bus.badvaddr  = bad_q;
   assign bus.epc       = epc_q;
   assign bus.exc_req   = (state_q == PEND);
   assign bus.stall_req = (state_q == PEND);
   assign bus.exc_cnt   = cnt_q;

endmodule

// File: tb/tb_exc_mem_window_chk.sv
// Purpose: scoreboard bench for exc_mem_window_chk. A driver applies directed and
// random M-stage traffic to a two-window instance and pushes the reference
// model's expected response; a monitor pops and compares each cycle. A second
// three-window instance with a 2-bit counter covers the extra window and
// counter saturation.
module tb_exc_mem_window_chk;

   typedef struct {
      logic        valid, rd, wr, bd, stall, flush, ack;
      logic [1:0]  size;
      logic [4:0]  exc_in;
      logic [31:0] addr, pc;
   } stim_t;

   typedef struct {
      logic        we;
      logic [4:0]  exc;
      logic [31:0] bad, epc;
      logic        req;
      logic [15:0] cnt;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_err    = 0;
   exp_t q[$];

   // Reference model state (DUT0)
   bit          m_pend = 0;
   logic [4:0]  m_exc  = 0;
   logic [31:0] m_bad  = 0;
   logic [31:0] m_epc  = 0;
   int          m_cnt  = 0;

   logic [31:0] base_tab [3] = '{32'h00007f00, 32'h00007f10, 32'h00007f20};

   exc_mem_window_chk_if #(.CNT_W(16)) if0 ();
   exc_mem_window_chk_if #(.CNT_W(2))  if1 ();

   exc_mem_window_chk #(
      .DEV_NUM(2), .DEV_BASE({32'h00007f10, 32'h00007f00}), .DEV_SIZE(12),
      .DEV_RO_OFF(8), .MEM_HI(32'h00002fff), .CNT_W(16)
   ) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

   exc_mem_window_chk #(
      .DEV_NUM(3), .DEV_BASE({32'h00007f20, 32'h00007f10, 32'h00007f00}),
      .DEV_SIZE(12), .DEV_RO_OFF(8), .MEM_HI(32'h00002fff), .CNT_W(2)
   ) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Exception code straight from the address-map rules.
   function automatic logic [4:0] ref_code(input stim_t s, input int nd);
      longint a = s.addr;
      bit any_dev = 0, ro = 0, legal, mis, narrow;
      if (!s.valid) return 5'd0;
      if (s.exc_in != 0) return s.exc_in;
      for (int i = 0; i < nd; i++) begin
         longint b = base_tab[i];
         if (a >= b && a < b + 12) begin
            any_dev = 1;
            if (a - b == 8) ro = 1;
         end
      end
      legal = (a <= 64'h2fff) || any_dev;
      case (s.size)
         2'd0: mis = 0;
         2'd1: mis = (a % 2) != 0;
         2'd2: mis = (a % 4) != 0;
         default: mis = 1;
      endcase
      narrow = any_dev && (s.size != 2'd2);
      if (s.wr) return (!legal || mis || narrow || ro) ? 5'd5 : 5'd0;
      if (s.rd) return (!legal || mis || narrow) ? 5'd4 : 5'd0;
      return 5'd0;
   endfunction

   function automatic stim_t mk(input bit valid, rd, wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [4:0] exc_in,
                                input logic [31:0] pc, input bit bd, stall, flush, ack);
      stim_t s;
      s.valid = valid; s.rd = rd; s.wr = wr; s.size = size; s.addr = addr;
      s.exc_in = exc_in; s.pc = pc; s.bd = bd; s.stall = stall; s.flush = flush;
      s.ack = ack;
      return s;
   endfunction

   function automatic stim_t idle(input bit ack);
      return mk(0, 0, 0, 2'd0, 32'h0, 5'd0, 32'h0, 0, 0, 0, ack);
   endfunction

   // Drive one cycle on DUT0 and push the model's expected response.
   task automatic apply(input stim_t s);
      exp_t e;
      logic [4:0] code;
      @(negedge clk);
      if0.valid_m = s.valid; if0.mem_rd = s.rd; if0.mem_wr = s.wr;
      if0.size = s.size; if0.addr = s.addr; if0.exc_in = s.exc_in;
      if0.pc_m = s.pc; if0.bd_m = s.bd; if0.stall = s.stall;
      if0.flush = s.flush; if0.exc_ack = s.ack;
      code = ref_code(s, 2);
      e.we = s.wr && s.valid && (code == 0) && !m_pend && !s.flush;
      if (!m_pend) begin
         if (!s.stall) begin
            if (s.flush) begin
               m_exc = 0;
            end else begin
               m_exc = code;
               if (code != 0) begin
                  m_epc = s.bd ? s.pc - 32'd4 : s.pc;
                  if (s.exc_in == 0) m_bad = s.addr;
                  else if (s.exc_in == 5'd4) m_bad = s.pc;
                  m_pend = 1;
                  if (m_cnt < 65535) m_cnt++;
               end
            end
         end
      end else if (s.ack) begin
         m_pend = 0;
         m_exc  = 0;
      end
      e.exc = m_exc; e.bad = m_bad; e.epc = m_epc; e.req = m_pend;
      e.cnt = 16'(m_cnt);
      q.push_back(e);
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s.valid = ($urandom_range(0, 9) != 0);
      s.rd    = 1'($urandom_range(0, 1));
      s.wr    = ($urandom_range(0, 2) == 0);
      s.size  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
         0: s.addr = 32'h00002ff0 + 32'($urandom_range(0, 31));
         1: s.addr = 32'h00007ef8 + 32'($urandom_range(0, 47));
         2: s.addr = $urandom & 32'h00003fff;
         default: s.addr = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) s.exc_in = 5'($urandom_range(1, 31));
      else if ($urandom_range(0, 15) == 0) s.exc_in = 5'd4;
      else s.exc_in = 5'd0;
      s.pc    = $urandom & 32'hfffffffc;
      s.bd    = 1'($urandom_range(0, 1));
      s.stall = ($urandom_range(0, 6) == 0);
      s.flush = ($urandom_range(0, 9) == 0);
      s.ack   = ($urandom_range(0, 2) == 0);
      return s;
   endfunction

   // Monitor: compares the strobe before the edge and registered outputs after it.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            check("we_safe", 32'(if0.we_safe), 32'(q[0].we));
            @(posedge clk);
            #1;
            e = q.pop_front();
            check("exc_w", 32'(if0.exc_w), 32'(e.exc));
            check("badvaddr", if0.badvaddr, e.bad);
            check("epc", if0.epc, e.epc);
            check("exc_req", 32'(if0.exc_req), 32'(e.req));
            check("stall_req", 32'(if0.stall_req), 32'(e.req));
            check("exc_cnt", 32'(if0.exc_cnt), 32'(e.cnt));
         end
      end
   end

   task automatic zero_if1();
      if1.stall = 0; if1.flush = 0; if1.valid_m = 0; if1.exc_in = 0;
      if1.addr = 0; if1.mem_rd = 0; if1.mem_wr = 0; if1.size = 0;
      if1.pc_m = 0; if1.bd_m = 0; if1.exc_ack = 0;
   endtask

   initial begin : main
      stim_t dir[$];
      int    wait_cnt;
      rst_n = 1'b0;
      if0.stall = 0; if0.flush = 0; if0.valid_m = 0; if0.exc_in = 0;
      if0.addr = 0; if0.mem_rd = 0; if0.mem_wr = 0; if0.size = 0;
      if0.pc_m = 0; if0.bd_m = 0; if0.exc_ack = 0;
      zero_if1();
      #12;
      check("rst_exc_w", 32'(if0.exc_w), 32'h0);
      check("rst_badvaddr", if0.badvaddr, 32'h0);
      check("rst_epc", if0.epc, 32'h0);
      check("rst_exc_req", 32'(if0.exc_req), 32'h0);
      check("rst_stall_req", 32'(if0.stall_req), 32'h0);
      check("rst_exc_cnt", 32'(if0.exc_cnt), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed sequence
      dir.push_back(mk(1, 1, 0, 2'd2, 32'h00007f08, 0, 32'h100, 0, 0, 0, 0));
      dir.push_back(mk(1, 0, 1, 2'd2, 32'h00007f08, 0, 32'h104, 0, 0, 0, 0));
      dir.push_back(idle(1));
      dir.push_back(mk(1, 1, 0, 2'd1, 32'h00001001, 0, 32'h108, 0, 0, 0, 0));
      dir.push_back(idle(1));
      dir.push_back(mk(1, 1, 0, 2'd0, 32'h00007f04, 0, 32'h10c, 0, 0, 0, 0));
      dir.push_back(idle(1));
      dir.push_back(mk(1, 0, 1, 2'd2, 32'h00007f0c, 0, 32'h110, 0, 0, 0, 0));
      dir.push_back(idle(1));
      dir.push_back(mk(1, 0, 1, 2'd2, 32'h00003000, 0, 32'h114, 0, 0, 0, 0));
      dir.push_back(idle(1));
      dir.push_back(mk(1, 0, 1, 2'd2, 32'h00002ffc, 0, 32'h118, 0, 0, 0, 0));
      dir.push_back(mk(1, 0, 0, 2'd2, 32'h00000040, 5'd4, 32'h00003004, 1, 0, 0, 0));
      dir.push_back(idle(1));
      dir.push_back(mk(1, 0, 0, 2'd2, 32'h00000040, 5'd10, 32'h00003004, 1, 0, 0, 0));
      dir.push_back(idle(1));
      dir.push_back(mk(1, 0, 1, 2'd3, 32'h00000100, 0, 32'h11c, 0, 0, 0, 0));
      dir.push_back(idle(1));
      dir.push_back(mk(1, 1, 0, 2'd2, 32'h00007f18, 0, 32'h120, 0, 0, 0, 0));
      dir.push_back(mk(1, 0, 1, 2'd2, 32'h00007f18, 0, 32'h124, 0, 0, 0, 0));
      dir.push_back(idle(1));
      dir.push_back(mk(1, 0, 1, 2'd2, 32'h00003000, 0, 32'h128, 0, 0, 1, 0));
      dir.push_back(mk(1, 0, 1, 2'd2, 32'h00003000, 0, 32'h12c, 0, 1, 0, 0));
      // Handshake hold: fault, three ignored cycles, then ack
      dir.push_back(mk(1, 0, 1, 2'd2, 32'h00003000, 0, 32'h200, 1, 0, 0, 0));
      dir.push_back(mk(1, 0, 1, 2'd2, 32'h00007f08, 0, 32'h204, 0, 0, 1, 0));
      dir.push_back(mk(1, 1, 0, 2'd1, 32'h00001001, 0, 32'h208, 0, 1, 0, 0));
      dir.push_back(mk(1, 0, 0, 2'd2, 32'h00000000, 5'd12, 32'h20c, 0, 0, 0, 0));
      dir.push_back(idle(1));
      dir.push_back(idle(1));
      dir.push_back(mk(1, 0, 1, 2'd2, 32'h00000010, 0, 32'h210, 0, 0, 0, 1));
      foreach (dir[i]) apply(dir[i]);

      for (int i = 0; i < 600; i++) apply(rand_stim());
      for (int i = 0; i < 3; i++) apply(idle(1));

      wait_cnt = 0;
      while (q.size() > 0 && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      check("drain", 32'(q.size()), 32'h0);

      // Reset while pending must drop exc_req without a clock edge
      @(negedge clk);
      if0.valid_m = 1; if0.mem_wr = 1; if0.mem_rd = 0; if0.size = 2'd2;
      if0.addr = 32'h00003000; if0.exc_in = 0; if0.stall = 0; if0.flush = 0;
      if0.exc_ack = 0;
      @(posedge clk);
      #1;
      check("pend_before_rst", 32'(if0.exc_req), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_req", 32'(if0.exc_req), 32'h0);
      check("async_rst_stall", 32'(if0.stall_req), 32'h0);
      check("async_rst_exc_w", 32'(if0.exc_w), 32'h0);
      if0.valid_m = 0; if0.mem_wr = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // Three-window instance with a 2-bit saturating counter
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if1.valid_m = 1; if1.mem_wr = 1; if1.mem_rd = 0; if1.size = 2'd2;
         if1.addr = 32'h00007f28; if1.pc_m = 32'h400 + 32'(k * 4);
         #2;
         check("d3_we_ro", 32'(if1.we_safe), 32'h0);
         @(posedge clk);
         #1;
         check("d3_exc_w", 32'(if1.exc_w), 32'h5);
         check("d3_badvaddr", if1.badvaddr, 32'h00007f28);
         check("d3_exc_req", 32'(if1.exc_req), 32'h1);
         @(negedge clk);
         if1.valid_m = 0; if1.mem_wr = 0; if1.exc_ack = 1;
         @(posedge clk);
         #1;
         check("d3_ack_req", 32'(if1.exc_req), 32'h0);
         check("d3_ack_exc_w", 32'(if1.exc_w), 32'h0);
         check("d3_cnt_sat", 32'(if1.exc_cnt), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
         @(negedge clk);
         if1.exc_ack = 0;
      end
      @(negedge clk);
      if1.valid_m = 1; if1.mem_rd = 1; if1.mem_wr = 0; if1.size = 2'd2;
      if1.addr = 32'h00007f24;
      @(posedge clk);
      #1;
      check("d3_ld_win2", 32'(if1.exc_w), 32'h0);
      check("d3_ld_win2_req", 32'(if1.exc_req), 32'h0);
      @(negedge clk);
      if1.mem_rd = 0; if1.mem_wr = 1;
      #2;
      check("d3_st_win2_we", 32'(if1.we_safe), 32'h1);
      @(negedge clk);
      zero_if1();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/exc_mem_window_chk.md
Name: exc_mem_window_chk

Overview:
- Parametrised memory-stage exception checker. It is the successor to the fixed two-timer address checker.
- Classifies each M-stage load/store against a RAM range and DEV_NUM device windows. Checks alignment, device access width and read-only device registers.
- Suppresses the faulting store strobe combinationally.
- Registers ExcCode, BadVAddr and EPC into the W stage, and holds them in a request/acknowledge handshake with CP0 until serviced.

Parameters:
- DEV_NUM, 2, number of device windows (1..8).
- DEV_BASE, {32'h00007f10, 32'h00007f00}, packed DEV_NUM x 32-bit window base addresses; window i is at bits [32i+31:32i].
- DEV_SIZE, 12, bytes per device window.
- DEV_RO_OFF, 8, byte offset inside every window that is read-only (timer count register).
- MEM_HI, 32'h00002fff, highest legal RAM byte address; RAM starts at 0.
- CNT_W, 16, width of the exception counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  pipeline stall; freezes the M->W registers
- flush  in  1  clears the M->W registers
- valid_m  in  1  M-stage instruction is valid
- exc_in  in  5  ExcCode carried from earlier stages; 0 = none
- addr  in  32  data address (ALU output)
- mem_rd  in  1  instruction is a load
- mem_wr  in  1  instruction is a store
- size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is illegal
- pc_m  in  32  PC of the M-stage instruction
- bd_m  in  1  instruction is in a delay slot
- exc_ack  in  1  CP0 has taken the exception
- we_safe  out  1  store strobe, gated by exceptions
- exc_w  out  5  registered ExcCode
- badvaddr  out  32  faulting address
- epc  out  32  exception PC
- exc_req  out  1  exception pending toward CP0
- stall_req  out  1  request to hold the pipeline while an exception is pending
- exc_cnt  out  CNT_W  saturating count of taken exceptions

Behaviour:
- Address classification (combinational, unsigned compares):
  - hit_mem = addr <= MEM_HI.
  - hit_dev[i] = DEV_BASE_i <= addr < DEV_BASE_i + DEV_SIZE.
  - legal = hit_mem | OR of hit_dev.
  - misalign = (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | size==3.
  - narrow = any hit_dev & size!=2. Devices accept word accesses only.
  - ro = any i with hit_dev[i] & (addr - DEV_BASE_i)==DEV_RO_OFF.
- Code selection (code_now):
  - exc_in!=0 → exc_in.
  - Otherwise mem_wr & (!legal | misalign | narrow | ro) → 5 (AdES).
  - Otherwise mem_rd & (!legal | misalign | narrow) → 4 (AdEL).
  - Otherwise 0.
  - If mem_wr and mem_rd are both high, the store rule applies.
  - If valid_m=0, code_now is 0.
- Write gating: we_safe = mem_wr & valid_m & code_now==0 & state==IDLE & !flush.
- FSM states: IDLE, PEND.
- Register update in IDLE, on the rising edge with stall=0:
  - flush=1 → exc_w cleared to 0; badvaddr and epc hold.
  - Otherwise exc_w <= code_now.
  - If code_now!=0: epc <= bd_m ? pc_m-4 : pc_m.
  - If the fault comes from this block (code 4/5 and exc_in==0): badvaddr <= addr.
  - If exc_in==4: badvaddr <= pc_m. This is the fetch AdEL case.
  - Otherwise badvaddr holds.
- IDLE→PEND: on any capture edge that loads exc_w!=0. exc_cnt increments on this edge and saturates at all-ones.
- In PEND:
  - exc_req=1 and stall_req=1.
  - exc_w, badvaddr and epc are frozen.
  - stall, flush and new M-stage data are ignored.
  - we_safe=0.
- PEND→IDLE: on an edge with exc_ack=1. On that same edge exc_w clears to 0; badvaddr and epc keep their values.
- exc_ack in IDLE is ignored.
- Latency: ExcCode is visible on exc_w/exc_req one cycle after the faulting M-stage cycle.
- Reset (async, rst_n=0):
  - state = IDLE.
  - exc_w, badvaddr, epc and exc_cnt = 0.
  - exc_req and stall_req = 0.
  - Reset asserted while in PEND drops exc_req immediately, without waiting for a clock.

Test Plan:
- Load word at 0x00007f08 with exc_in=0 → no exception, exc_w=0. Store word at 0x00007f08 → we_safe=0; next cycle exc_w=5, badvaddr=0x7f08, exc_req=1.
- Load half at 0x00001001 → exc_w=4, badvaddr=0x1001. Load byte at 0x00007f04 → exc_w=4 (narrow device access).
- Store word at 0x00007f0c (just past window 0) and at 0x00003000 → exc_w=5 each; store word at 0x00002ffc → we_safe=1, no exception.
- exc_in=4, pc_m=0x00003004, bd_m=1 → exc_w=4, badvaddr=0x3004, epc=0x3000. The same case with exc_in=10 → exc_w=10 and badvaddr unchanged.
- Handshake: fault, then hold exc_ack=0 for 3 cycles while feeding new faults and flush → exc_w/epc stay frozen and stall_req=1. Pulse exc_ack → next cycle exc_req=0, exc_w=0 and exc_cnt has incremented by exactly 1.
- Assert rst_n=0 mid-PEND → exc_req falls without a clock edge; set DEV_NUM=3 with a third base at 0x7f20 and confirm a store to 0x7f28 raises exc_w=5.
